mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waited for mem_ready before abort (1..65535).
REQ-002 SHALL have port clk  input  1  positive-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch address, stable while if_req high.
REQ-006 SHALL have port if_rdata  output  32  fetched instruction, valid with if_ack.
REQ-007 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port d_req / d_we  input  1 / 1  data request / write-enable, held until d_ack.
REQ-009 SHALL have port d_addr / d_wdata  input  32 / 32  data address / write data.
REQ-010 SHALL have port d_rdata  output  32  load data, valid with d_ack.
REQ-011 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-012 SHALL have port mem_req / mem_we  output  1 / 1  shared-memory request / write.
REQ-013 SHALL have port mem_addr / mem_wdata  output  32 / 32  registered address / write data.
REQ-014 SHALL have port mem_rdata / mem_ready  input  32 / 1  memory read data / completion.
REQ-015 SHALL have port if_stall / d_stall  output  1 / 1  combinational: req & ~ack per port.
REQ-016 SHALL have port err  output  1  one-cycle timeout pulse, coincident with ack.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; all outputs except stalls registered.
REQ-018 IDLE: any req pending -> select owner per REQ-024, latch addr/we/wdata onto mem_*, assert mem_req, go BUSY; else stay.
REQ-019 BUSY: mem_req held high, mem_* stable; mem_ready sampled high -> capture mem_rdata into owner rdata, deassert mem_req, go RESP.
REQ-020 RESP: owner ack high exactly one cycle; requests ignored; next state IDLE.
REQ-021 Minimum latency req-to-ack = 3 cycles (mem_ready high in first BUSY cycle); back-to-back request restarts in IDLE cycle after RESP.
REQ-022 Timeout counter (16 bit) SHALL clear on entry to BUSY, increment each BUSY cycle; reaching TIMEOUT_CYC without mem_ready -> rdata = 32'hDEADBEEF, err pulse, go RESP.
REQ-023 Writes SHALL return d_rdata unchanged (previous value).
REQ-024 Selection with both requests in IDLE: per Configuration; single request always granted.
REQ-025 Request deasserted mid-BUSY SHALL NOT abort the transfer; ack still issued.
REQ-026 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, mem_req/mem_we/acks/err = 0, mem_addr/mem_wdata/rdata = 0, counter = 0, priority pointer = IF-last (data next); in-flight transfer abandoned, no ack.
REQ-028 First arbitration SHALL occur on the first rising clk edge with rst_n high.

Configuration
REQ-029 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: both pending -> grant port not granted last (pointer updated on grant).
REQ-030 Macro undefined: both pending -> data port always wins (fixed priority; IF starvation permitted).

Verification
REQ-031 Single fetch: if_req, if_addr=0x40, mem_ready in first BUSY cycle, mem_rdata=0x20080005 -> if_ack cycle 3, if_rdata=0x20080005, if_stall low after ack.
REQ-032 Simultaneous if_req+d_req, macro undefined -> d_ack first, if_ack after; macro defined, second contention -> grants alternate D, IF, D, IF.
REQ-033 Store d_we=1 d_addr=0x100 d_wdata=0xCAFEF00D -> mem_we=1, mem_addr=0x100, mem_wdata=0xCAFEF00D held until mem_ready, d_ack one pulse.
REQ-034 TIMEOUT_CYC=4, mem_ready never high -> after 4 BUSY cycles err and ack pulse, rdata=0xDEADBEEF, mem_req low.
REQ-035 rst_n low during BUSY -> mem_req 0 immediately, no ack; after release, pending d_req granted (pointer reset value).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory port, with transfer timeout.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter  int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned AW          = 32,
  localparam int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          if_stall,
  output logic          d_stall,
  output logic          err
);

  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 1: data port owns the transfer
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          grant_d_c;
  logic          timeout_c;
  logic          done_c;
  logic [DW-1:0] resp_data_c;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;             // 1: data port was granted last

  assign grant_d_c = d_req & (~if_req | ~last_d_q);
`else
  assign grant_d_c = d_req;
`endif

  // Current BUSY cycle is the TIMEOUT_CYC-th one since entry.
  assign timeout_c = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYC);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    done_c      = 1'b0;
    resp_data_c = mem_rdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d     = grant_d_c;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_d_c & d_we;
          mem_addr_d  = grant_d_c ? d_addr : if_addr;
          mem_wdata_d = grant_d_c ? d_wdata : '0;
          cnt_d       = '0;
          state_d     = BUSY;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_d_d    = grant_d_c;
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ready) begin
          done_c = 1'b1;
        end else if (timeout_c) begin
          done_c      = 1'b1;
          err_d       = 1'b1;
          resp_data_c = TIMEOUT_DATA;
        end
        if (done_c) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            d_ack_d = 1'b1;
            // Stores leave the load-data register untouched.
            if (!mem_we_q) d_rdata_d = resp_data_c;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data_c;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule
